// File: rtl/fifo_skid_stage.sv
// Two-entry skid stage between a FIFO read port and a ready/valid consumer.
// fifo_pop depends only on registered state, fifo_valid, flush and rst, so out_ready never reaches it combinationally.
module fifo_skid_stage #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter bit          FLUSH_DROPS_OUTPUT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  transfer;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign transfer  = out_valid & out_ready;
    // rst gating keeps the upstream FIFO untouched while reset is held
    assign fifo_pop  = fifo_valid & ~flush & ~rst & (state != TWO);

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            if (FLUSH_DROPS_OUTPUT) begin
                state <= EMPTY;
            end else begin
                // skid is dropped; a main entry consumed this cycle is not kept, so it is never emitted twice
                case (state)
                    TWO:     state <= transfer ? EMPTY : ONE;
                    ONE:     if (transfer) state <= EMPTY;
                    default: state <= EMPTY;
                endcase
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (fifo_pop) begin
                        main_q <= fifo_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (fifo_pop && transfer) begin
                        main_q <= fifo_data;
                    end else if (fifo_pop) begin
                        skid_q <= fifo_data;
                        state  <= TWO;
                    end else if (transfer) begin
                        state  <= EMPTY;
                    end
                end
                TWO: begin
                    if (transfer) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_skid_stage.sv
// Self-checking bench: an upstream FIFO model feeds both flush variants; a reference queue scores the dropping variant every cycle.
module tb_fifo_skid_stage;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_valid;
    logic [DW-1:0] fifo_data;
    logic          flush;
    logic          out_ready;
    logic          fifo_pop, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic          fifo_pop2, out_valid2;
    logic [DW-1:0] out_data2;
    logic [1:0]    occupancy2;

    int            n_cmp;
    int            n_bad;
    logic          gate;
    logic [DW-1:0] src[$];
    logic [DW-1:0] model[$];

    always #5 clk = ~clk;

    fifo_skid_stage #(.DATA_WIDTH(DW), .FLUSH_DROPS_OUTPUT(1'b1)) dut (
        .clk(clk), .rst(rst), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
        .fifo_pop(fifo_pop), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .occupancy(occupancy)
    );

    fifo_skid_stage #(.DATA_WIDTH(DW), .FLUSH_DROPS_OUTPUT(1'b0)) dut_keep (
        .clk(clk), .rst(rst), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
        .fifo_pop(fifo_pop2), .flush(flush), .out_valid(out_valid2),
        .out_data(out_data2), .out_ready(out_ready), .occupancy(occupancy2)
    );

    task automatic refresh();
        fifo_valid = gate && (src.size() != 0);
        fifo_data  = (src.size() != 0) ? src[0] : '0;
    endtask

    // one clock; the upstream FIFO dequeues when the DUT popped in the cycle just ended
    task automatic step();
        logic p;
        @(negedge clk);
        p = fifo_pop;
        @(posedge clk);
        #1;
        if (p === 1'b1 && src.size() != 0) void'(src.pop_front());
        refresh();
    endtask

    task automatic scoreboard_monitor();
        logic          exp_pop;
        logic [DW-1:0] exp_data;
        forever begin
            @(negedge clk);
            if (rst) begin
                model.delete();
            end else begin
                exp_pop = fifo_valid & ~flush & (model.size() != 2);
                n_cmp++;
                if (fifo_pop !== exp_pop) begin
                    n_bad++;
                    $display("FAIL sb_pop t=%0t got %b exp %b", $time, fifo_pop, exp_pop);
                end
                n_cmp++;
                if (occupancy !== 2'(model.size())) begin
                    n_bad++;
                    $display("FAIL sb_occupancy t=%0t got %0d exp %0d", $time, occupancy, model.size());
                end
                n_cmp++;
                if (out_valid !== (model.size() != 0)) begin
                    n_bad++;
                    $display("FAIL sb_out_valid t=%0t got %b exp %b", $time, out_valid, model.size() != 0);
                end
                if (out_valid === 1'b1 && out_ready && model.size() != 0) begin
                    exp_data = model.pop_front();
                    n_cmp++;
                    if (out_data !== exp_data) begin
                        n_bad++;
                        $display("FAIL sb_order t=%0t got %h exp %h", $time, out_data, exp_data);
                    end
                end
                if (flush) model.delete();
                if (fifo_pop === 1'b1) model.push_back(fifo_data);
            end
        end
    endtask

    task automatic reset_all();
        gate      = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        src.delete();
        refresh();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        gate = 1'b1;
        src.push_back(DW'(7));
        refresh();
        #2;
        n_cmp++; if (fifo_pop !== 1'b0)  begin n_bad++; $display("FAIL rst_pop got %b exp 0", fifo_pop); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL rst_occupancy got %0d exp 0", occupancy); end
        n_cmp++; if (out_data !== '0)    begin n_bad++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        n_cmp++; if (fifo_pop2 !== 1'b0 || out_valid2 !== 1'b0) begin
            n_bad++; $display("FAIL rst_keep got pop=%b valid=%b exp 0/0", fifo_pop2, out_valid2);
        end
        step();
        step();
        rst = 1'b0;
        refresh();
        #1;
        n_cmp++; if (fifo_pop !== 1'b1) begin n_bad++; $display("FAIL rst_release_pop got %b exp 1", fifo_pop); end
        step();
        n_cmp++; if (out_data !== DW'(7) || occupancy !== 2'd1) begin
            n_bad++; $display("FAIL rst_first_entry got %h/%0d exp 7/1", out_data, occupancy);
        end
    endtask

    task automatic test_single();
        reset_all();
        repeat (6) src.push_back(DW'('hA));
        gate      = 1'b1;
        out_ready = 1'b1;
        refresh();
        #1;
        n_cmp++; if (fifo_pop !== 1'b1 || occupancy !== 2'd0) begin
            n_bad++; $display("FAIL single_start got pop=%b occ=%0d exp 1/0", fifo_pop, occupancy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (out_data !== DW'('hA) || occupancy !== 2'd1 || fifo_pop !== 1'b1 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL single_cycle%0d got data=%h occ=%0d pop=%b exp a/1/1", i, out_data, occupancy, fifo_pop);
            end
        end
    endtask

    task automatic test_back_to_back();
        reset_all();
        for (int i = 0; i < 20; i++) src.push_back(DW'(100 + i));
        gate      = 1'b1;
        out_ready = 1'b1;
        refresh();
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++;
            if (out_data !== DW'(100 + i) || out_valid !== 1'b1 || fifo_pop !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_%0d got data=%0d valid=%b pop=%b exp %0d/1/1", i, out_data, out_valid, fifo_pop, 100 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_q[$];
        int            budget;
        reset_all();
        src = '{DW'(1), DW'(2), DW'(3)};
        gate = 1'b1;
        refresh();
        repeat (5) step();
        n_cmp++;
        if (occupancy !== 2'd2 || fifo_pop !== 1'b0 || out_data !== DW'(1) || src.size() != 1) begin
            n_bad++;
            $display("FAIL bp_full got occ=%0d pop=%b data=%h left=%0d exp 2/0/1/1", occupancy, fifo_pop, out_data, src.size());
        end
        exp_q = '{DW'(1), DW'(2), DW'(3)};
        out_ready = 1'b1;
        budget = 10;
        while (exp_q.size() != 0 && budget > 0) begin
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (out_data !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL bp_drain got %h exp %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            step();
            budget--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_timeout got %0d left exp 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        reset_all();
        src = '{DW'(5), DW'(6), DW'(7)};
        gate = 1'b1;
        refresh();
        step();
        step();
        n_cmp++;
        if (occupancy !== 2'd2 || occupancy2 !== 2'd2) begin
            n_bad++; $display("FAIL flush_pre got %0d/%0d exp 2/2", occupancy, occupancy2);
        end
        flush = 1'b1;
        refresh();
        #1;
        n_cmp++;
        if (fifo_pop !== 1'b0 || fifo_pop2 !== 1'b0) begin
            n_bad++; $display("FAIL flush_pop got %b/%b exp 0/0", fifo_pop, fifo_pop2);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_bad++; $display("FAIL flush_drop got valid=%b occ=%0d exp 0/0", out_valid, occupancy);
        end
        n_cmp++;
        if (occupancy2 !== 2'd1 || out_data2 !== DW'(5) || out_valid2 !== 1'b1) begin
            n_bad++; $display("FAIL flush_keep got occ=%0d data=%h exp 1/5", occupancy2, out_data2);
        end
        flush     = 1'b0;
        gate      = 1'b0;
        out_ready = 1'b1;
        refresh();
        step();
        n_cmp++;
        if (occupancy2 !== 2'd0 || out_valid2 !== 1'b0) begin
            n_bad++; $display("FAIL flush_keep_skid_gone got occ=%0d valid=%b data=%h exp 0/0", occupancy2, out_valid2, out_data2);
        end
    endtask

    task automatic test_async_reset();
        reset_all();
        src = '{DW'(1), DW'(2), DW'(3)};
        gate = 1'b1;
        refresh();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_pop !== 1'b0 || occupancy !== 2'd0 || out_valid2 !== 1'b0) begin
            n_bad++; $display("FAIL async_rst got valid=%b pop=%b occ=%0d exp 0/0/0", out_valid, fifo_pop, occupancy);
        end
        step();
        rst = 1'b0;
        #1;
        step();
        n_cmp++;
        if (out_data !== DW'(3) || occupancy !== 2'd1) begin
            n_bad++; $display("FAIL async_rst_resume got %h/%0d exp 3/1", out_data, occupancy);
        end
    endtask

    task automatic test_random();
        reset_all();
        for (int i = 0; i < 10000; i++) begin
            while (src.size() < 3) src.push_back(DW'($urandom));
            gate      = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            refresh();
            step();
        end
        flush     = 1'b0;
        gate      = 1'b0;
        out_ready = 1'b1;
        refresh();
        repeat (4) step();
        n_cmp++;
        if (occupancy !== 2'd0) begin
            n_bad++; $display("FAIL random_drain got %0d exp 0", occupancy);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        gate       = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        fifo_valid = 1'b0;
        fifo_data  = '0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_skid_stage.md
FIFO_SKID_STAGE -- requirements
Module: fifo_skid_stage

Interface
REQ-001: Parameter DATA_WIDTH, default 32, width of each entry carried from the FIFO read side to the consumer.
REQ-002: Parameter FLUSH_DROPS_OUTPUT, default 1; 1 = flush also clears the presented output, 0 = flush clears only the skid entry.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, asynchronous and active-high.
REQ-005: fifo_valid  input  1  upstream FIFO holds at least one entry.
REQ-006: fifo_data  input  DATA_WIDTH  upstream FIFO head entry (data_out of the FIFO).
REQ-007: fifo_pop  output  1  dequeue strobe to the upstream FIFO.
REQ-008: flush  input  1  synchronous discard of held entries.
REQ-009: out_valid  output  1  out_data holds a valid entry.
REQ-010: out_data  output  DATA_WIDTH  entry presented to the consumer.
REQ-011: out_ready  input  1  consumer accepts out_data this cycle.
REQ-012: occupancy  output  2  number of entries held (0..2).

Function
REQ-013: The block SHALL hold two registers, main and skid, and a state machine with states EMPTY (0 held), ONE (main valid), TWO (main and skid valid).
REQ-014: fifo_pop SHALL equal fifo_valid & ~flush & (state != TWO), computed from registered state only; no combinational path from out_ready to fifo_pop.
REQ-015: out_valid SHALL be 1 exactly in ONE and TWO; out_data SHALL always be the main register; occupancy SHALL be 0/1/2 for EMPTY/ONE/TWO.
REQ-016: A transfer SHALL occur when out_valid & out_ready; a pop SHALL occur when fifo_pop is 1.
REQ-017: EMPTY: pop -> main<=fifo_data, ONE; otherwise stay EMPTY (out_ready ignored).
REQ-018: ONE: pop & transfer -> main<=fifo_data, stay ONE; pop & ~transfer -> skid<=fifo_data, TWO; ~pop & transfer -> EMPTY; neither -> stay ONE.
REQ-019: TWO: transfer -> main<=skid, ONE; no transfer -> stay TWO; no pop possible.
REQ-020: Latency: an entry popped in cycle N SHALL appear on out_data with out_valid in cycle N+1 when the stage was EMPTY or ONE-with-transfer.
REQ-021: Sustained throughput SHALL be one entry per cycle when fifo_valid and out_ready are held at 1.
REQ-022: Entries SHALL leave in the exact order popped; none duplicated or lost except by flush.
REQ-023: flush with FLUSH_DROPS_OUTPUT=1 SHALL force next state EMPTY regardless of other inputs; a transfer in the flush cycle still counts as consumed.
REQ-024: flush with FLUSH_DROPS_OUTPUT=0 SHALL force TWO->ONE (skid dropped, main kept) and leave EMPTY/ONE otherwise unchanged except for the transfer: ONE with transfer -> EMPTY.
REQ-025: fifo_pop SHALL never assert when fifo_valid=0 (no underflow of the upstream FIFO).
REQ-026: out_data and skid SHALL hold their value when not loaded; out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-027: While rst=1, state SHALL be EMPTY, out_valid=0, fifo_pop=0, occupancy=0, main and skid = 0, asynchronously.
REQ-028: Reset asserted mid-operation SHALL discard held entries immediately; first pop possible on the first rising edge after rst deasserts.

Verification
REQ-029: Reset then fifo_valid=1, data 0xA, out_ready=1 held -> fifo_pop=1 each cycle, out_data=0xA one cycle after the pop, occupancy=1.
REQ-030: Stream 0x1,0x2,0x3 with out_ready=0 -> two pops only, occupancy=2, fifo_pop=0, out_data=0x1 stable; release out_ready -> outputs 0x1,0x2,0x3 in order.
REQ-031: Random fifo_valid/out_ready toggling, 10000 cycles -> scoreboard order exact, no pop with fifo_valid=0, occupancy never >2.
REQ-032: TWO state, flush=1 with FLUSH_DROPS_OUTPUT=1 -> next cycle out_valid=0, occupancy=0, fifo_pop=0 during flush cycle.
REQ-033: TWO holding 0x5,0x6, flush with FLUSH_DROPS_OUTPUT=0 -> occupancy=1, out_data=0x5, 0x6 never emitted.
REQ-034: rst asserted asynchronously between edges while in TWO -> out_valid=0 and fifo_pop=0 before next edge.
